// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : Bridges a 32-bit fetch port and a load/store port onto a
//             byte-wide memory bus, with CPU pause (rdy) and fetch flush.
//  Revision : 1.0  initial release
// ============================================================================
module mem_ctrl (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic        if_req_in,
   input  logic [31:0] if_addr_in,
   output logic        if_ack_out,
   output logic [31:0] if_data_out,
   input  logic        dat_req_in,
   input  logic        dat_wr_in,
   input  logic [1:0]  dat_size_in,
   input  logic [31:0] dat_addr_in,
   input  logic [31:0] dat_wdata_in,
   output logic        dat_ack_out,
   output logic [31:0] dat_rdata_out,
   input  logic        flush_in,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [7:0]  mem_dout,
   input  logic [7:0]  mem_din,
   output logic        busy_out
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IF_RD  = 2'd1,
      DAT_RD = 2'd2,
      DAT_WR = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic [2:0]  nbytes_q;   // transfer length in bytes (1, 2 or 4)
   logic [2:0]  idx_q;      // next byte to issue on the bus
   logic [2:0]  cap_q;      // number of read bytes captured so far
   logic        pend_q;     // a read byte issued last cycle awaits capture
   logic        ack_if_q, ack_dat_q, ack_hold_q;
   logic        can_accept, accept_dat, accept_if;
   logic        last_rd, last_wr, flush_abort;

   // Acks are held back while the bus is paused; acceptance waits two cycles
   // after an ack so the requester has time to drop its request.
   assign can_accept    = rdy_in && !ack_if_q && !ack_dat_q && !ack_hold_q;
   assign if_ack_out    = ack_if_q & rdy_in;
   assign dat_ack_out   = ack_dat_q & rdy_in;
   assign if_data_out   = rdata_q;
   assign dat_rdata_out = rdata_q;
   assign busy_out      = (state_q != IDLE);

   // State register
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next-state decode and byte-bus drive
   always_comb begin
      state_d     = state_q;
      accept_dat  = 1'b0;
      accept_if   = 1'b0;
      last_rd     = 1'b0;
      last_wr     = 1'b0;
      flush_abort = 1'b0;
      mem_addr    = 32'd0;
      mem_wr      = 1'b0;
      mem_dout    = 8'd0;
      case (state_q)
         IDLE: begin
            if (can_accept) begin
               if (dat_req_in) begin
                  accept_dat = 1'b1;
                  state_d    = dat_wr_in ? DAT_WR : DAT_RD;
               end else if (if_req_in && !flush_in) begin
                  accept_if = 1'b1;
                  state_d   = IF_RD;
               end
            end
         end
         IF_RD, DAT_RD: begin
            mem_addr = addr_q + {29'd0, idx_q};
            if (state_q == IF_RD && flush_in) begin
               flush_abort = 1'b1;
               state_d     = IDLE;
            end else if (rdy_in && pend_q && (cap_q + 3'd1 == nbytes_q)) begin
               last_rd = 1'b1;
               state_d = IDLE;
            end
         end
         DAT_WR: begin
            mem_addr = addr_q + {29'd0, idx_q};
            mem_wr   = rdy_in;
            case (idx_q[1:0])
               2'd0:    mem_dout = wdata_q[7:0];
               2'd1:    mem_dout = wdata_q[15:8];
               2'd2:    mem_dout = wdata_q[23:16];
               default: mem_dout = wdata_q[31:24];
            endcase
            if (rdy_in && (idx_q + 3'd1 == nbytes_q)) begin
               last_wr = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Request latching, byte sequencing, read capture and ack generation
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         addr_q     <= 32'd0;
         wdata_q    <= 32'd0;
         rdata_q    <= 32'd0;
         nbytes_q   <= 3'd0;
         idx_q      <= 3'd0;
         cap_q      <= 3'd0;
         pend_q     <= 1'b0;
         ack_if_q   <= 1'b0;
         ack_dat_q  <= 1'b0;
         ack_hold_q <= 1'b0;
      end else begin
         ack_hold_q <= if_ack_out | dat_ack_out;
         if (rdy_in) begin
            ack_if_q  <= 1'b0;
            ack_dat_q <= 1'b0;
         end
         if (accept_dat || accept_if) begin
            addr_q  <= accept_dat ? dat_addr_in : if_addr_in;
            wdata_q <= dat_wdata_in;
            rdata_q <= 32'd0;
            idx_q   <= 3'd0;
            cap_q   <= 3'd0;
            pend_q  <= 1'b0;
            if (accept_if)                nbytes_q <= 3'd4;
            else if (dat_size_in == 2'b00) nbytes_q <= 3'd1;
            else if (dat_size_in == 2'b01) nbytes_q <= 3'd2;
            else                          nbytes_q <= 3'd4;
         end else if (state_q == DAT_WR) begin
            // a write byte only counts when the bus was ours
            if (rdy_in) idx_q <= idx_q + 3'd1;
            if (last_wr) ack_dat_q <= 1'b1;
         end else if (state_q == IF_RD || state_q == DAT_RD) begin
            if (flush_abort) begin
               pend_q <= 1'b0;
            end else if (rdy_in) begin
               if (pend_q) begin
                  rdata_q[{cap_q[1:0], 3'b000} +: 8] <= mem_din;
                  cap_q <= cap_q + 3'd1;
               end
               if (idx_q < nbytes_q) begin
                  pend_q <= 1'b1;
                  idx_q  <= idx_q + 3'd1;
               end else begin
                  pend_q <= 1'b0;
               end
               if (last_rd) begin
                  if (state_q == IF_RD) ack_if_q  <= 1'b1;
                  else                  ack_dat_q <= 1'b1;
               end
            end else begin
               // paused: in-flight byte is lost, resume from first uncaptured
               pend_q <= 1'b0;
               idx_q  <= cap_q;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl
//  Purpose  : Self-checking bench for mem_ctrl with a byte RAM and a
//             byte-array reference memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rdy = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = 32'd0;
   logic        if_ack;
   logic [31:0] if_data;
   logic        dat_req = 1'b0;
   logic        dat_wr = 1'b0;
   logic [1:0]  dat_size = 2'b00;
   logic [31:0] dat_addr = 32'd0;
   logic [31:0] dat_wdata = 32'd0;
   logic        dat_ack;
   logic [31:0] dat_rdata;
   logic        flush = 1'b0;
   logic [31:0] mem_addr;
   logic        mem_wr;
   logic [7:0]  mem_dout;
   logic [7:0]  mem_din;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  ram  [0:65535];
   logic [7:0]  refm [0:65535];
   logic        poke_en = 1'b0;
   logic [15:0] poke_a = 16'd0;
   logic [7:0]  poke_d = 8'd0;

   logic [31:0] tr_addr [$];
   logic        tr_wr   [$];
   logic [7:0]  tr_dout [$];

   always #5 clk = ~clk;

   mem_ctrl dut (
      .clk_in        (clk),
      .rst_n_in      (rst_n),
      .rdy_in        (rdy),
      .if_req_in     (if_req),
      .if_addr_in    (if_addr),
      .if_ack_out    (if_ack),
      .if_data_out   (if_data),
      .dat_req_in    (dat_req),
      .dat_wr_in     (dat_wr),
      .dat_size_in   (dat_size),
      .dat_addr_in   (dat_addr),
      .dat_wdata_in  (dat_wdata),
      .dat_ack_out   (dat_ack),
      .dat_rdata_out (dat_rdata),
      .flush_in      (flush),
      .mem_addr      (mem_addr),
      .mem_wr        (mem_wr),
      .mem_dout      (mem_dout),
      .mem_din       (mem_din),
      .busy_out      (busy)
   );

   // Byte RAM: read data appears the cycle after the address
   always @(posedge clk) begin
      if (poke_en)     ram[poke_a] <= poke_d;
      else if (mem_wr) ram[mem_addr[15:0]] <= mem_dout;
      mem_din <= ram[mem_addr[15:0]];
   end

   // ---------------- reference model ----------------
   function automatic int nbytes(input bit fetch, input logic [1:0] size);
      if (fetch) return 4;
      if (size == 2'b00) return 1;
      if (size == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ref_read(input logic [31:0] a, input int n);
      logic [31:0] v = 32'd0;
      for (int k = 0; k < n; k++) begin
         logic [31:0] ak = a + 32'(k);
         v[8*k +: 8] = refm[ak[15:0]];
      end
      return v;
   endfunction

   task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input int n);
      for (int k = 0; k < n; k++) begin
         logic [31:0] ak = a + 32'(k);
         refm[ak[15:0]] = d[8*k +: 8];
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic poke(input logic [31:0] a, input logic [7:0] d);
      poke_en = 1'b1; poke_a = a[15:0]; poke_d = d;
      refm[a[15:0]] = d;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   // Issues one request, stalls rdy in cycles [stall_at, stall_at+stall_len),
   // and records the bus per cycle; cycle 1 follows the acceptance edge.
   task automatic do_xfer(input bit fetch, input bit wr, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input int stall_at, input int stall_len,
                          output int ack_cyc, output logic [31:0] data,
                          output int other_ack);
      int cyc = 0;
      tr_addr.delete(); tr_wr.delete(); tr_dout.delete();
      ack_cyc = -1; data = 32'd0; other_ack = 0;
      if (fetch) begin
         if_req = 1'b1; if_addr = addr;
      end else begin
         dat_req = 1'b1; dat_wr = wr; dat_size = size;
         dat_addr = addr; dat_wdata = wdata;
      end
      while (ack_cyc < 0 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         rdy = !(cyc >= stall_at && cyc < stall_at + stall_len);
         if (cyc == 2) begin
            // requests changing mid-transfer must be ignored
            dat_addr = ~dat_addr; dat_wdata = ~dat_wdata;
            dat_size = ~dat_size; if_addr = ~if_addr;
         end
         @(negedge clk);
         tr_addr.push_back(mem_addr); tr_wr.push_back(mem_wr); tr_dout.push_back(mem_dout);
         if (fetch ? dat_ack : if_ack) other_ack++;
         if (fetch ? if_ack : dat_ack) begin
            ack_cyc = cyc;
            data = fetch ? if_data : dat_rdata;
         end
      end
      if_req = 1'b0; dat_req = 1'b0; rdy = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      if_req = 1'b1; dat_req = 1'b1; dat_wr = 1'b1;
      idle(2);
      @(negedge clk);
      n_tests++;
      if ({if_ack, dat_ack, mem_wr, busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 0000", {if_ack, dat_ack, mem_wr, busy});
      end
      n_tests++;
      if (mem_addr !== 32'd0 || mem_dout !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_bus: got addr %h dout %h expected 0", mem_addr, mem_dout);
      end
      n_tests++;
      if (if_data !== 32'd0 || dat_rdata !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_data: got %h/%h expected 0", if_data, dat_rdata);
      end
      if_req = 1'b0; dat_req = 1'b0; dat_wr = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(2);
   endtask

   task automatic test_fetch;
      int ac, oa;
      logic [31:0] d;
      poke(32'h1000, 8'hEE); poke(32'h1001, 8'hFF);
      poke(32'h1002, 8'hC0); poke(32'h1003, 8'h00);
      do_xfer(1'b1, 1'b0, 2'b10, 32'h1000, 32'd0, 0, 0, ac, d, oa);
      n_tests++;
      if (ac !== 6) begin n_fail++; $display("FAIL fetch_lat: got %0d expected 6", ac); end
      n_tests++;
      if (d !== 32'h00C0FFEE) begin n_fail++; $display("FAIL fetch_data: got %h expected 00c0ffee", d); end
      for (int k = 0; k < 4; k++) begin
         logic [31:0] obs = (k < tr_addr.size()) ? tr_addr[k] : 32'hxxxxxxxx;
         n_tests++;
         if (obs !== 32'h1000 + 32'(k)) begin
            n_fail++;
            $display("FAIL fetch_addr%0d: got %h expected %h", k, obs, 32'h1000 + 32'(k));
         end
      end
      n_tests++;
      if (oa !== 0) begin n_fail++; $display("FAIL fetch_other_ack: got %0d expected 0", oa); end
      idle(3);
   endtask

   task automatic test_store_load;
      int ac, oa;
      logic [31:0] d;
      do_xfer(1'b0, 1'b1, 2'b01, 32'h2001, 32'h1234BEEF, 0, 0, ac, d, oa);
      ref_write(32'h2001, 32'h1234BEEF, 2);
      n_tests++;
      if (ac !== 3) begin n_fail++; $display("FAIL sh_lat: got %0d expected 3", ac); end
      n_tests++;
      if (tr_wr.size() < 3 || {tr_wr[0], tr_addr[0], tr_dout[0]} !== {1'b1, 32'h2001, 8'hEF}
          || {tr_wr[1], tr_addr[1], tr_dout[1]} !== {1'b1, 32'h2002, 8'hBE} || tr_wr[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL sh_bus: got wr %b%b addr %h dout %h %h expected 11 2001 ef be",
                  tr_wr[0], tr_wr[1], tr_addr[0], tr_dout[0], tr_dout[1]);
      end
      idle(3);
      do_xfer(1'b0, 1'b0, 2'b01, 32'h2001, 32'd0, 0, 0, ac, d, oa);
      n_tests++;
      if (ac !== 4) begin n_fail++; $display("FAIL lh_lat: got %0d expected 4", ac); end
      n_tests++;
      if (d !== 32'h0000BEEF) begin n_fail++; $display("FAIL lh_data: got %h expected 0000beef", d); end
      idle(3);
      do_xfer(1'b0, 1'b1, 2'b00, 32'h2003, 32'hFFFFFFA5, 0, 0, ac, d, oa);
      ref_write(32'h2003, 32'hFFFFFFA5, 1);
      idle(3);
      do_xfer(1'b0, 1'b0, 2'b00, 32'h2003, 32'd0, 0, 0, ac, d, oa);
      n_tests++;
      if (d !== 32'h000000A5 || ac !== 3) begin
         n_fail++;
         $display("FAIL lb_data: got %h at cycle %0d expected 000000a5 at cycle 3", d, ac);
      end
      idle(3);
   endtask

   task automatic test_arbitration;
      int cyc = 0, dack = -1, iack = -1;
      logic [31:0] idata = 32'd0, a1 = 32'd0;
      logic        w1 = 1'b0;
      logic [7:0]  d1 = 8'd0;
      dat_req = 1'b1; dat_wr = 1'b1; dat_size = 2'b00;
      dat_addr = 32'h0003_0000; dat_wdata = 32'h0000_0041;
      if_req = 1'b1; if_addr = 32'h0000_4010;
      while ((dack < 0 || iack < 0) && cyc < 30) begin
         @(posedge clk); #1;
         cyc++;
         @(negedge clk);
         if (cyc == 1) begin a1 = mem_addr; w1 = mem_wr; d1 = mem_dout; end
         if (dat_ack && dack < 0) begin dack = cyc; dat_req = 1'b0; end
         if (if_ack && iack < 0) begin iack = cyc; idata = if_data; if_req = 1'b0; end
      end
      if_req = 1'b0; dat_req = 1'b0;
      ref_write(32'h0003_0000, 32'h41, 1);
      n_tests++;
      if ({w1, a1, d1} !== {1'b1, 32'h0003_0000, 8'h41}) begin
         n_fail++;
         $display("FAIL arb_store: got wr %b addr %h dout %h expected 1 00030000 41", w1, a1, d1);
      end
      n_tests++;
      if (dack !== 2) begin n_fail++; $display("FAIL arb_dat_ack: got %0d expected 2", dack); end
      n_tests++;
      if (iack !== 10) begin n_fail++; $display("FAIL arb_if_ack: got %0d expected 10", iack); end
      n_tests++;
      if (idata !== ref_read(32'h4010, 4)) begin
         n_fail++;
         $display("FAIL arb_if_data: got %h expected %h", idata, ref_read(32'h4010, 4));
      end
      idle(3);
   endtask

   task automatic test_stall;
      int ac, oa, nwr;
      logic [31:0] d, wd;
      poke(32'h5000, 8'h44); poke(32'h5001, 8'h33);
      poke(32'h5002, 8'h22); poke(32'h5003, 8'h11);
      do_xfer(1'b0, 1'b0, 2'b10, 32'h5000, 32'd0, 3, 3, ac, d, oa);
      nwr = 0;
      foreach (tr_wr[i]) if (tr_wr[i] !== 1'b0) nwr++;
      n_tests++;
      if (nwr !== 0) begin n_fail++; $display("FAIL lw_stall_wr: got %0d write cycles expected 0", nwr); end
      n_tests++;
      if (d !== 32'h11223344) begin n_fail++; $display("FAIL lw_stall_data: got %h expected 11223344", d); end
      n_tests++;
      if (ac !== 10) begin n_fail++; $display("FAIL lw_stall_lat: got %0d expected 10", ac); end
      n_tests++;
      if (tr_addr.size() < 7 || tr_addr[5] !== 32'h5001 || tr_addr[6] !== 32'h5002) begin
         n_fail++;
         $display("FAIL lw_stall_reissue: got %h %h expected 00005001 00005002", tr_addr[5], tr_addr[6]);
      end
      idle(3);
      wd = $urandom;
      do_xfer(1'b0, 1'b1, 2'b10, 32'h5010, wd, 2, 2, ac, d, oa);
      ref_write(32'h5010, wd, 4);
      nwr = 0;
      foreach (tr_wr[i]) if (tr_wr[i] === 1'b1) nwr++;
      n_tests++;
      if (ac !== 7 || nwr !== 4) begin
         n_fail++;
         $display("FAIL sw_stall: got ack %0d writes %0d expected ack 7 writes 4", ac, nwr);
      end
      n_tests++;
      if (tr_wr.size() < 3 || tr_wr[1] !== 1'b0 || tr_wr[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL sw_stall_glitch: got %b%b expected 00", tr_wr[1], tr_wr[2]);
      end
      idle(3);
      do_xfer(1'b0, 1'b0, 2'b10, 32'h5010, 32'd0, 0, 0, ac, d, oa);
      n_tests++;
      if (d !== wd) begin n_fail++; $display("FAIL sw_stall_readback: got %h expected %h", d, wd); end
      idle(3);
   endtask

   task automatic test_flush;
      int ac, oa, bad = 0;
      logic [31:0] d;
      if_req = 1'b1; if_addr = 32'h4020;
      idle(2);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; if_req = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || if_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_ifrd: got busy %b ack %b expected 0 0", busy, if_ack);
      end
      repeat (6) begin
         @(negedge clk);
         if (if_ack !== 1'b0 || mem_wr !== 1'b0) bad++;
      end
      n_tests++;
      if (bad !== 0) begin n_fail++; $display("FAIL flush_no_ack: got %0d bad cycles expected 0", bad); end
      @(posedge clk); #1;
      if_req = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      if_req = 1'b0; flush = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_block: got busy %b expected 0", busy); end
      idle(2);
      flush = 1'b1;
      do_xfer(1'b0, 1'b0, 2'b01, 32'h4030, 32'd0, 0, 0, ac, d, oa);
      n_tests++;
      if (ac !== 4 || d !== ref_read(32'h4030, 2)) begin
         n_fail++;
         $display("FAIL flush_load: got %h at %0d expected %h at 4", d, ac, ref_read(32'h4030, 2));
      end
      idle(3);
      do_xfer(1'b0, 1'b1, 2'b00, 32'h4031, 32'h0000005C, 0, 0, ac, d, oa);
      ref_write(32'h4031, 32'h5C, 1);
      n_tests++;
      if (ac !== 2) begin n_fail++; $display("FAIL flush_store: got %0d expected 2", ac); end
      flush = 1'b0;
      idle(3);
   endtask

   task automatic test_reset_mid;
      int bad = 0;
      dat_req = 1'b1; dat_wr = 1'b1; dat_size = 2'b10;
      dat_addr = 32'h6000; dat_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++;
      if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre: got wr %b expected 1", mem_wr); end
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({mem_wr, mem_addr, mem_dout, busy, dat_ack} !== 43'd0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got wr %b addr %h dout %h busy %b expected 0",
                  mem_wr, mem_addr, mem_dout, busy);
      end
      dat_req = 1'b0;
      idle(2);
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (dat_ack !== 1'b0 || busy !== 1'b0) bad++;
      end
      n_tests++;
      if (bad !== 0) begin n_fail++; $display("FAIL rst_mid_no_ack: got %0d bad cycles expected 0", bad); end
      idle(2);
   endtask

   task automatic test_random;
      poke(32'hFFFF_FFFE, 8'($urandom)); poke(32'hFFFF_FFFF, 8'($urandom));
      poke(32'h0000_0000, 8'($urandom)); poke(32'h0000_0001, 8'($urandom));
      for (int it = 0; it < 40; it++) begin
         int kind = $urandom_range(0, 2);
         bit fetch = (kind == 0);
         bit wr = (kind == 2);
         logic [1:0] size = 2'($urandom_range(0, 3));
         logic [31:0] addr = 32'h4000 + 32'($urandom_range(0, 240));
         logic [31:0] wd = $urandom;
         int n, sat = 0, slen = 0, exp_ac, ac, oa, errs = 0, wi = 0;
         logic [31:0] d;
         if (it == 0) addr = 32'hFFFF_FFFE;
         n = nbytes(fetch, size);
         if (wr && $urandom_range(0, 1) == 1) begin
            sat = $urandom_range(1, n); slen = $urandom_range(1, 3);
         end
         exp_ac = wr ? n + 1 + slen : n + 2;
         do_xfer(fetch, wr, size, addr, wd, sat, slen, ac, d, oa);
         if (wr) begin
            foreach (tr_wr[i]) if (tr_wr[i] === 1'b1) begin
               if (wi >= n || tr_addr[i] !== addr + 32'(wi) || tr_dout[i] !== wd[8*wi +: 8]) errs++;
               wi++;
            end
            if (wi != n) errs++;
            ref_write(addr, wd, n);
         end else begin
            for (int k = 0; k < n; k++)
               if (k >= tr_addr.size() || tr_addr[k] !== addr + 32'(k) || tr_wr[k] !== 1'b0) errs++;
            n_tests++;
            if (d !== ref_read(addr, n)) begin
               n_fail++;
               $display("FAIL rand%0d_data: got %h expected %h", it, d, ref_read(addr, n));
            end
         end
         n_tests++;
         if (ac !== exp_ac || oa !== 0) begin
            n_fail++;
            $display("FAIL rand%0d_ack: got cycle %0d other %0d expected cycle %0d other 0", it, ac, oa, exp_ac);
         end
         n_tests++;
         if (errs !== 0) begin n_fail++; $display("FAIL rand%0d_bus: got %0d bad bytes expected 0", it, errs); end
         idle(3);
      end
   endtask

   initial begin
      test_reset();
      for (int i = 0; i < 256; i++) poke(32'h4000 + 32'(i), 8'($urandom));
      test_fetch();
      test_store_load();
      test_arbitration();
      test_stall();
      test_flush();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
